max_pool_stream: RTL
====================

// Module: max_pool_stream
// PURPOSE
//   Streaming 2x2, stride-2 max-pooling engine for a raster-scan feature map.
//   Accepts one pixel per handshake and buffers horizontal pair maxima of even rows in a line buffer.
//   Emits one pooled pixel per 2x2 window with valid/ready flow control.
//   Sits between a convolution/activation stage and the next CNN layer.
// PARAMETERS
//   DATA_W  16  pixel width in bits
//   IMG_W   28  input map width in pixels; must be even, >=2
//   IMG_H   28  input map height in pixels; must be even, >=2
//   SIGNED  0   1: two's-complement compare; 0: unsigned compare
// PORTS
//   clk        in   1       clock; all state on rising edge
//   rst        in   1       asynchronous, active-high reset
//   clear      in   1       synchronous frame restart; same effect as rst except line-buffer contents
//   in_valid   in   1       input pixel valid
//   in_ready   out  1       block can accept a pixel
//   in_data    in   DATA_W  input pixel, raster order (row-major, col 0 first)
//   out_valid  out  1       pooled pixel valid
//   out_ready  in   1       downstream accepts the pooled pixel
//   out_data   out  DATA_W  pooled pixel (max of 2x2 window)
//   out_last   out  1       qualifies out_data as the last pooled pixel of the frame
// BEHAVIOUR
//   - Reset (rst or clear):
//     - out_valid=0, out_data=0, out_last=0.
//     - col=0, row=0, pair register=0.
//     - Line buffer is not cleared.
//   - Accept: a pixel is accepted when in_valid & in_ready.
//     - in_ready = ~out_valid | out_ready (combinational).
//     - in_ready is 0 while clear=1.
//   - Per accepted pixel at (row, col):
//     - col even: latch the pixel into the pair register.
//     - col odd: hmax = max(pair register, in_data).
//       - row even: line_buf[col>>1] <= hmax.
//       - row odd: out_data <= max(line_buf[col>>1], hmax); out_valid <= 1;
//         out_last <= (row==IMG_H-1 && col==IMG_W-1).
//   - Counters:
//     - col wraps IMG_W-1 -> 0 and increments row.
//     - row wraps IMG_H-1 -> 0; the next frame follows with no gap.
//   - Latency: out_valid rises one cycle after the 4th pixel of a window is accepted.
//   - Backpressure: while out_valid & ~out_ready, out_data and out_last are held stable.
//   - Output handshake:
//     - out_valid & out_ready with a new result the same cycle: the output register reloads and out_valid stays 1.
//     - Handshake without a new result: out_valid <= 0, out_last <= 0.
//   - Compare: ties yield the common value.
//     - SIGNED=1 uses $signed operands; SIGNED=0 uses unsigned operands.
//   - Simultaneous events:
//     - clear with in_valid=1: clear wins and the pixel is dropped.
//     - rst mid-frame: outputs are zero immediately (async); the next pixel is treated as (0,0).
//   - Throughput: 1 pixel/cycle input; output rate is 1/4 of input.
//   - Odd IMG_W or IMG_H: elaboration-time error ($error in a generate check).
// STRUCTURE
//   - Shared package cnn_pool_pkg:
//     - function max2(a, b, is_signed)
//     - localparam LB_DEPTH = IMG_W/2
//     - clog2 helper
//   - Sub-module pool_line_buffer: LB_DEPTH x DATA_W register array.
//     - One synchronous write port and one combinational read port.
//     - Index is col>>1.
//   - Top holds counters, pair register, output register and handshake logic; no FSM beyond the counters.
// TESTING (DATA_W=16, IMG_W=4, IMG_H=4 unless noted)
//   1. Frame 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last=1 only with 15.
//   2. SIGNED=1, window {0xFFFF,0x0002,0x0001,0x0000} -> out_data 0x0002; SIGNED=0 same window -> 0xFFFF.
//   3. Frame 0..15 with out_ready=0 for 5 cycles after the first result -> out_data held at 5; in_ready=0; final stream still 5,7,13,15.
//   4. clear after 6 pixels accepted, then frame 16..31 -> outputs 21,23,29,31 only.
//   5. rst pulsed asynchronously mid-frame -> out_valid/out_data/out_last = 0 before the next clk edge; next frame pools correctly.
//   6. Two back-to-back frames with random in_valid gaps and random out_ready -> outputs 5,7,13,15,21,23,29,31; out_last after 15 and 31.

Source files
------------

// File: rtl/cnn_pool_pkg.sv
// cnn_pool_pkg: shared compare, sizing and width helpers for the pooling engine
package cnn_pool_pkg;

    localparam int MAX_W = 64;

    function automatic int clog2(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic int lb_depth(input int img_w);
        return img_w / 2;
    endfunction

    function automatic logic [MAX_W-1:0] max2(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input logic is_signed);
        return (is_signed ? ($signed(a) >= $signed(b)) : (a >= b)) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one row of horizontal pair maxima, sync write and async read at the same index
module pool_line_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 14,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // store the even-row pair maximum; contents survive reset so no reset branch
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 stride-2 max pooling with valid/ready on both sides
module max_pool_stream
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int LB_DEPTH = lb_depth(IMG_W);
    localparam int CW       = clog2(IMG_W);
    localparam int RW       = clog2(IMG_H);
    localparam int AW       = clog2(LB_DEPTH);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 || DATA_W < 1 || DATA_W > MAX_W)
    begin : g_bad_param
        $error("max_pool_stream: IMG_W/IMG_H must be even and >= 2, DATA_W must be 1..64");
    end

    // widen to the package compare width, sign-extending only in signed mode
    function automatic logic [MAX_W-1:0] ext(input logic [DATA_W-1:0] v);
        return SIGNED ? MAX_W'($signed(v)) : MAX_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] pmax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [MAX_W-1:0] m;
        m = max2(ext(a), ext(b), SIGNED);
        return m[DATA_W-1:0];
    endfunction

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DATA_W-1:0] r_pair;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;

    logic              w_acc;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_emit;
    logic              w_lb_we;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_lb_rd;
    logic [DATA_W-1:0] w_hmax;
    logic [DATA_W-1:0] w_vmax;

    assign in_ready   = ~clear & (~r_out_valid | out_ready);
    assign w_acc      = in_valid & in_ready;
    assign w_col_last = r_col == CW'(IMG_W - 1);
    assign w_row_last = r_row == RW'(IMG_H - 1);
    assign w_emit     = w_acc & r_col[0] & r_row[0];
    assign w_lb_we    = w_acc & r_col[0] & ~r_row[0];
    assign w_idx      = AW'(r_col >> 1);
    assign w_hmax     = pmax(r_pair, in_data);
    assign w_vmax     = pmax(w_lb_rd, w_hmax);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (AW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_idx   (w_idx),
        .i_wdata (w_hmax),
        .o_rdata (w_lb_rd)
    );

    // raster counters, pair register and the output register with its handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_pair      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (clear) begin
            r_col       <= '0;
            r_row       <= '0;
            r_pair      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col <= w_col_last ? '0 : r_col + CW'(1);
                if (w_col_last) r_row <= w_row_last ? '0 : r_row + RW'(1);
                if (!r_col[0]) r_pair <= in_data;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_vmax;
                r_out_last  <= w_row_last & w_col_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

endmodule
